// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the SDP RAM stream reader.
// Optional level reporting in the top is enabled by defining SDP_RD_LEVEL_EN.
package sdp_ram_pkg;

    localparam int unsigned OUT_BUF_DEPTH = 2;

    typedef logic [1:0] buf_cnt_t;

    // Modular pointer difference, masked to a pointer of w bits (wrap bit included).
    function automatic logic [31:0] ptr_used(input logic [31:0] wr, input logic [31:0] rd,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/sdp_ram_stream_reader_stream_out_buf.sv
// Two-entry in-order register buffer: head register drives the stream directly.
module stream_out_buf
    import sdp_ram_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [P_DATA_WIDTH-1:0] push_data_i,
    input  logic                    pop_i,
    output logic [P_DATA_WIDTH-1:0] data_o,
    output logic                    valid_o,
    output buf_cnt_t                cnt_o
);

    logic [P_DATA_WIDTH-1:0] head_q, head_d;
    logic [P_DATA_WIDTH-1:0] tail_q, tail_d;
    buf_cnt_t                cnt_q, cnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new word lands behind whatever remains.
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end else begin
                    head_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o  = head_q;
    assign valid_o = (cnt_q != 2'd0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/sdp_ram_stream_reader.sv
// Read-side controller for the sync FIFO's SDP RAM; hides 1-cycle read latency.
// Define SDP_RD_LEVEL_EN to add the registered level_o output.
module sdp_ram_stream_reader
    import sdp_ram_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 8,
    parameter int unsigned P_ADDR_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [P_ADDR_WIDTH:0]   wr_ptr_i,
    output logic [P_ADDR_WIDTH:0]   rd_ptr_o,
    output logic                    ram_rd_o,
    output logic [P_ADDR_WIDTH-1:0] ram_addr_rd_o,
    input  logic [P_DATA_WIDTH-1:0] ram_data_rd_i,
    output logic [P_DATA_WIDTH-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i
`ifdef SDP_RD_LEVEL_EN
    ,
    output logic [P_ADDR_WIDTH+1:0] level_o
`endif
);

    logic [P_ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                  inflight_q;
    logic                  ram_empty;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;
    buf_cnt_t              buf_cnt;

    assign ram_empty = (wr_ptr_i == rd_ptr_q);
    assign pop       = valid_o && ready_i;

    // Words held downstream of the RAM once this cycle's pop has left.
    assign occ   = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = !rst_i && !ram_empty && (occ <= 3'd1);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (issue) begin
            rd_ptr_d = rd_ptr_q + {{P_ADDR_WIDTH{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= issue;
        end
    end

    assign ram_rd_o      = issue;
    assign ram_addr_rd_o = rd_ptr_q[P_ADDR_WIDTH-1:0];
    assign rd_ptr_o      = rd_ptr_q;

    stream_out_buf #(
        .P_DATA_WIDTH(P_DATA_WIDTH)
    ) u_out_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (inflight_q),
        .push_data_i(ram_data_rd_i),
        .pop_i      (pop),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .cnt_o      (buf_cnt)
    );

`ifdef SDP_RD_LEVEL_EN
    logic [31:0]           level_sum;
    logic [P_ADDR_WIDTH+1:0] level_q;

    assign level_sum = ptr_used({{(31 - P_ADDR_WIDTH) {1'b0}}, wr_ptr_i},
                                {{(31 - P_ADDR_WIDTH) {1'b0}}, rd_ptr_q}, P_ADDR_WIDTH + 1)
                     + {31'd0, inflight_q} + {30'd0, buf_cnt};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '0;
        end else begin
            level_q <= level_sum[P_ADDR_WIDTH+1:0];
        end
    end

    assign level_o = level_q;
`endif

endmodule

// File: tb/tb_sdp_ram_stream_reader.sv
// Scoreboard bench for sdp_ram_stream_reader with a behavioural SDP RAM and writer.
module tb_sdp_ram_stream_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW:0]   wr_ptr_i = '0;
    logic [AW:0]   rd_ptr_o;
    logic          ram_rd_o;
    logic [AW-1:0] ram_addr_rd_o;
    logic [DW-1:0] ram_data_rd_i = '0;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
`ifdef SDP_RD_LEVEL_EN
    logic [AW+1:0] level_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_log [$];
    int            written = 0;
    int            popped  = 0;

    always #5 clk_i = ~clk_i;

    sdp_ram_stream_reader #(
        .P_DATA_WIDTH(DW),
        .P_ADDR_WIDTH(AW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_ptr_i     (wr_ptr_i),
        .rd_ptr_o     (rd_ptr_o),
        .ram_rd_o     (ram_rd_o),
        .ram_addr_rd_o(ram_addr_rd_o),
        .ram_data_rd_i(ram_data_rd_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
`ifdef SDP_RD_LEVEL_EN
        ,
        .level_o      (level_o)
`endif
    );

    // Registered-read RAM model.
    always @(posedge clk_i) begin
        if (ram_rd_o) ram_data_rd_i <= mem[ram_addr_rd_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Writer: store word in RAM, advance write pointer, record expectation.
    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr_i[AW-1:0]] = d;
        wr_ptr_i = wr_ptr_i + 1'b1;
        exp_q.push_back(d);
        written++;
    endtask

    function automatic int used_words();
        logic [AW:0] u;
        u = wr_ptr_i - rd_ptr_o;
        return int'(u);
    endfunction

    task automatic wait_drain(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || valid_o) && cyc < 400) begin
            tick();
            cyc++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    // Monitor: checks popped words in order, stall stability, RAM addresses and level.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    int            lvl_prev   = 0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_stall = 1'b0;
            lvl_prev   = 0;
        end else begin
            if (ram_rd_o) addr_log.push_back(ram_addr_rd_o);
            if (prev_stall) begin
                check("stall_valid", valid_o, 1);
                check("stall_data", data_o, prev_data);
            end
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
`ifdef SDP_RD_LEVEL_EN
            check("level", level_o, lvl_prev);
            lvl_prev = written - popped;
`endif
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    check("pop_data", data_o, exp_q.pop_front());
                end
                popped++;
            end
        end
    end

    initial begin
        logic [DW-1:0] w0;
        int            cnt;
        int            cyc;

        // Reset state
        #2;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_rdptr", rd_ptr_o, 0);
        check("rst_ramrd", ram_rd_o, 0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // Single word latency
        mem[0] = 8'hA5;
        wr_ptr_i = 5'd1;
        exp_q.push_back(8'hA5);
        written++;
        #1;
        check("single_ramrd", ram_rd_o, 1);
        check("single_addr", ram_addr_rd_o, 0);
        tick();
        check("single_valid_n1", valid_o, 0);
        tick();
        check("single_valid_n2", valid_o, 1);
        check("single_data_n2", data_o, 8'hA5);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("single_valid_after_pop", valid_o, 0);
        check("single_rdptr", rd_ptr_o, 1);

        // Streaming from a fresh reset
        rst_i = 1'b1;
        #1;
        exp_q.delete();
        wr_ptr_i = '0;
        written = 0;
        popped = 0;
        tick();
        rst_i = 1'b0;
        tick();
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        cyc = 0;
        while (!valid_o && cyc < 10) begin
            tick();
            cyc++;
        end
        cnt = 0;
        while (valid_o && cnt < 40) begin
            cnt++;
            tick();
        end
        check("stream_consecutive", cnt, 16);
        check("stream_rdptr", rd_ptr_o, 5'h10);
        wait_drain("stream");

        // Backpressure
        ready_i = 1'b0;
        w0 = DW'($urandom);
        push_word(w0);
        for (int i = 1; i < 8; i++) push_word(DW'($urandom));
        repeat (10) tick();
        check("bp_valid", valid_o, 1);
        check("bp_data", data_o, w0);
        check("bp_rdptr", rd_ptr_o, 5'h12);
        ready_i = 1'b1;
        wait_drain("bp");

        // Wrap: bring pointers to 0x1F, then cross the address boundary
        for (int i = 0; i < 7; i++) push_word(DW'($urandom));
        wait_drain("prewrap");
        check("prewrap_rdptr", rd_ptr_o, 5'h1F);
        addr_log.delete();
        for (int i = 0; i < 4; i++) push_word(DW'(8'hC0 + i));
        wait_drain("wrap");
        check("wrap_addr_cnt", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            check("wrap_addr0", addr_log[0], 4'hF);
            check("wrap_addr1", addr_log[1], 4'h0);
            check("wrap_addr2", addr_log[2], 4'h1);
            check("wrap_addr3", addr_log[3], 4'h2);
        end
        check("wrap_rdptr", rd_ptr_o, 5'h03);

        // Random ready with random writer
        cnt = 0;
        cyc = 0;
        while (cnt < 200 && cyc < 5000) begin
            tick();
            cyc++;
            ready_i = $urandom_range(0, 1) == 1;
            if (used_words() < DEPTH && $urandom_range(0, 2) != 0) begin
                push_word(DW'($urandom));
                cnt++;
            end
        end
        check("rand_pushed", cnt, 200);
        ready_i = 1'b1;
        wait_drain("rand");

        // Reset mid-stream
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push_word(DW'($urandom));
        repeat (3) tick();
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_data", data_o, 0);
        check("midrst_rdptr", rd_ptr_o, 0);
        check("midrst_ramrd", ram_rd_o, 0);
        exp_q.delete();
        wr_ptr_i = '0;
        written = 0;
        popped = 0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) push_word(DW'(8'h50 + i));
        wait_drain("postrst");
        check("postrst_rdptr", rd_ptr_o, 5'h03);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
